// File: rtl/ne_fp_add_arb.sv
// Round-robin arbiter sharing one pipelined FP/INT adder among NREQ requesters, with
// in-order tag tracking and a credit-protected response FIFO. Optional NE_ADD_ARB_STATS_EN adds counters.
module ne_fp_add_arb #(
    parameter int NREQ       = 4,
    parameter int BWA        = 40,
    parameter int BWZ        = 41,
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_vld,
    output logic [NREQ-1:0]           req_rdy,
    input  logic [NREQ*BWA-1:0]       req_a,
    input  logic [NREQ*BWA-1:0]       req_b,
    input  logic [NREQ*3-1:0]         req_mode,
    output logic [BWA-1:0]            add_a,
    output logic [BWA-1:0]            add_b,
    output logic [2:0]                add_mode,
    input  logic [BWZ-1:0]            add_z,
    output logic                      rsp_vld,
    input  logic                      rsp_rdy,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [BWZ-1:0]            rsp_z,
    output logic                      busy
`ifdef NE_ADD_ARB_STATS_EN
    ,
    output logic [15:0]               stat_ops,
    output logic [15:0]               stat_stall
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1) + 1;

    logic [BWA-1:0] a_arr    [NREQ];
    logic [BWA-1:0] b_arr    [NREQ];
    logic [2:0]     mode_arr [NREQ];

    logic [IDW-1:0] rr_ptr, win, idx, push_id;
    logic           found, issue_ok, grant, push, pop;
    logic [CW-1:0]  fifo_occ, inflight;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [IDW+BWZ-1:0] mem [FIFO_DEPTH];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g]    = req_a[g*BWA +: BWA];
        assign b_arr[g]    = req_b[g*BWA +: BWA];
        assign mode_arr[g] = req_mode[g*3 +: 3];
    end

    // Credit uses registered counts only; a pop in this cycle frees its slot next cycle.
    assign issue_ok = (fifo_occ + inflight) < CW'(FIFO_DEPTH);

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_vld[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant = found & issue_ok & rst_n;

    // Idle cycles present zero operands so the adder never sees stale data.
    always_comb begin
        req_rdy  = '0;
        add_a    = '0;
        add_b    = '0;
        add_mode = '0;
        if (grant) begin
            req_rdy[win] = 1'b1;
            add_a        = a_arr[win];
            add_b        = b_arr[win];
            add_mode     = mode_arr[win];
        end
    end

    if (LAT == 0) begin : g_direct
        assign push     = grant;
        assign push_id  = win;
        assign inflight = '0;
    end else begin : g_pipe
        logic [LAT-1:0] tag_vld;
        logic [IDW-1:0] tag_id [LAT];
        logic [CW-1:0]  inflight_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_vld    <= '0;
                inflight_q <= '0;
                for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
            end else begin
                tag_vld[0] <= grant;
                tag_id[0]  <= win;
                for (int i = 1; i < LAT; i++) begin
                    tag_vld[i] <= tag_vld[i-1];
                    tag_id[i]  <= tag_id[i-1];
                end
                inflight_q <= inflight_q + CW'(grant) - CW'(tag_vld[LAT-1]);
            end
        end

        assign push     = tag_vld[LAT-1];
        assign push_id  = tag_id[LAT-1];
        assign inflight = inflight_q;
    end

    assign rsp_vld = (fifo_occ != '0);
    assign pop     = rsp_vld & rsp_rdy;
    assign busy    = (inflight != '0) | (fifo_occ != '0);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_occ <= '0;
        end else begin
            if (grant) rr_ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
            if (push)  wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            fifo_occ <= fifo_occ + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the storage array is not reset; emptiness is tracked by fifo_occ and outputs are masked.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_id, add_z};
    end

    assign {rsp_id, rsp_z} = rsp_vld ? mem[rd_ptr] : '0;

`ifdef NE_ADD_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (grant && stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if ((|req_vld) && !issue_ok && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (fifo_occ < CW'(FIFO_DEPTH)));

endmodule
